// File: rtl/encode42_key.sv
// Four raw push-buttons to 2-bit key codes: per-key synchroniser and debounce,
// press-edge detection, priority encode (key[3] highest), one-deep valid/ready output.
module encode42_key #(
  parameter  int DEBOUNCE_CYC = 1_000_000,
  localparam int CNT_W        = $clog2(DEBOUNCE_CYC + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  output logic [3:0] key_state,
  output logic [1:0] code,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       drop
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [3:0]            s1_q, s2_q;
  logic [3:0]            key_state_q, key_state_d;
  logic [3:0]            ks_q;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            code_q, code_d;
  logic                  drop_q, drop_d;
  state_e                state_q, state_d;

  logic [3:0] press;
  logic       evt;
  logic       multi;
  logic [1:0] ecode;

  // A level is accepted only after it has differed from the stable level
  // for DEBOUNCE_CYC consecutive cycles; any return to stable restarts the count.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    key_state_d = key_state_q;
    cnt_d       = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (s2_q[i] == key_state_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        key_state_d[i] = s2_q[i];
        cnt_d[i]       = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign press = key_state_q & ~ks_q;
  assign evt   = |press;
  assign multi = (press & (press - 4'd1)) != 4'd0;

  always_comb begin
    ecode = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (press[i]) ecode = 2'(i);
    end
  end

  // Output holding register: a press arriving while a stalled code is held is lost.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    drop_d  = evt & multi;
    case (state_q)
      IDLE: begin
        if (evt) begin
          code_d  = ecode;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (code_ready) begin
          if (evt) code_d = ecode;
          else     state_d = IDLE;
        end else if (evt) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      key_state_q <= '0;
      ks_q        <= '0;
      cnt_q       <= '0;
      code_q      <= '0;
      drop_q      <= 1'b0;
      state_q     <= IDLE;
    end else begin
      s1_q        <= key;
      s2_q        <= s1_q;
      key_state_q <= key_state_d;
      ks_q        <= key_state_q;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      drop_q      <= drop_d;
      state_q     <= state_d;
    end
  end

  assign key_state  = key_state_q;
  assign code       = code_q;
  assign code_valid = (state_q == HOLD);
  assign drop       = drop_q;

endmodule

// File: tb/tb_encode42_key.sv
// Self-checking bench for encode42_key: directed button scenarios plus random
// bouncing, scored against a history-window reference model and a code scoreboard.
module tb_encode42_key;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic [3:0] key_state;
  logic [1:0] code;
  logic       code_valid;
  logic       code_ready;
  logic       drop;

  encode42_key #(.DEBOUNCE_CYC(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .key        (key),
    .key_state  (key_state),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .drop       (drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int hs_cnt   = 0;
  int drop_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model. hist holds raw key samples as they pass through the
  // synchroniser: the newest entry is what s1 holds, the one before is what
  // the debouncer sees. A bit flips once its last D observed values all differ
  // from the stable level.
  logic [3:0] hist[$];
  logic [3:0] m_ks      = '0;
  logic [3:0] m_ks_prev = '0;
  logic [3:0] m_ks_next;
  logic [3:0] m_press;
  bit         m_full    = 1'b0;
  bit         m_drop    = 1'b0;
  bit         m_all;
  int         m_hi;
  logic [1:0] exp_q[$];

  always @(posedge clk) begin
    if (rst) begin
      hist = {4'b0000, 4'b0000};
      m_ks = '0;
      m_ks_prev = '0;
      m_full = 1'b0;
      m_drop = 1'b0;
      exp_q.delete();
    end else begin
      m_press = m_ks & ~m_ks_prev;
      m_hi = 0;
      for (int i = 0; i < 4; i++) if (m_press[i]) m_hi = i;
      m_drop = (m_press != 0) && (($countones(m_press) > 1) || (m_full && !code_ready));
      if ((m_press != 0) && (!m_full || code_ready)) begin
        exp_q.push_back(2'(m_hi));
        m_full = 1'b1;
      end else if (m_full && code_ready) begin
        m_full = 1'b0;
      end
      m_ks_next = m_ks;
      if (hist.size() >= D + 1) begin
        for (int i = 0; i < 4; i++) begin
          m_all = 1'b1;
          for (int k = 0; k < D; k++)
            if (hist[hist.size() - 2 - k][i] == m_ks[i]) m_all = 1'b0;
          if (m_all) m_ks_next[i] = hist[hist.size() - 2][i];
        end
      end
      m_ks_prev = m_ks;
      m_ks = m_ks_next;
      hist.push_back(key);
      if (hist.size() > D + 2) void'(hist.pop_front());
    end
  end

  // Monitor: samples mid-cycle, when inputs and outputs are both settled for the next edge.
  always @(negedge clk) begin
    check("key_state", 32'(key_state), 32'(m_ks));
    check("code_valid", 32'(code_valid), 32'(m_full));
    check("drop", 32'(drop), 32'(m_drop));
    if (drop) drop_cnt++;
    if (code_valid && code_ready && !rst) begin
      hs_cnt++;
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("code", 32'(code), 32'(exp_q.pop_front()));
    end
  end

  task automatic run(input logic [3:0] k, input logic rd, input int n);
    key = k;
    code_ready = rd;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int hs0, dr0;

  task automatic mark();
    hs0 = hs_cnt;
    dr0 = drop_cnt;
  endtask

  task automatic expect_counts(input string name, input int hs, input int dr);
    check({name, "_handshakes"}, 32'(hs_cnt - hs0), 32'(hs));
    check({name, "_drops"}, 32'(drop_cnt - dr0), 32'(dr));
  endtask

  int hold;

  initial begin
    rst = 1'b1;
    key = 4'b0000;
    code_ready = 1'b0;
    run(4'b0000, 1'b0, 3);
    rst = 1'b0;
    run(4'b0000, 1'b1, 6);

    // single key press with ready high
    mark();
    run(4'b0001, 1'b1, 12);
    run(4'b0000, 1'b1, 12);
    expect_counts("single_press", 1, 0);

    // bouncing key2, 2-cycle levels, then settles high
    mark();
    for (int t = 0; t < 12; t++) run(((t % 4) < 2) ? 4'b0100 : 4'b0000, 1'b1, 1);
    run(4'b0100, 1'b1, 12);
    run(4'b0000, 1'b1, 12);
    expect_counts("bounce", 1, 0);

    // simultaneous key3 and key1
    mark();
    run(4'b1010, 1'b1, 12);
    run(4'b0000, 1'b1, 12);
    expect_counts("simultaneous", 1, 1);

    // stalled consumer, second press discarded
    mark();
    run(4'b0001, 1'b0, 8);
    run(4'b0011, 1'b0, 8);
    run(4'b0011, 1'b1, 4);
    run(4'b0000, 1'b1, 12);
    expect_counts("stall", 1, 1);

    // back-to-back: key3 press lands on the handshake cycle of key0
    mark();
    run(4'b0001, 1'b1, 1);
    run(4'b1001, 1'b1, 12);
    run(4'b0000, 1'b1, 12);
    expect_counts("back_to_back", 2, 0);

    // reset while a code is pending and key0 is held
    mark();
    run(4'b0001, 1'b0, 8);
    rst = 1'b1;
    run(4'b0001, 1'b0, 1);
    rst = 1'b0;
    run(4'b0001, 1'b1, 12);
    run(4'b0000, 1'b1, 12);
    expect_counts("reset_held", 1, 0);

    // random bouncing buttons, random stalls, rare resets
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        key = 4'($urandom);
        hold = $urandom_range(1, 9);
      end
      hold--;
      code_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 499) == 0);
      @(posedge clk);
      #2;
    end
    rst = 1'b0;
    run(4'b0000, 1'b1, 20);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
